mult_seq_param: RTL and testbench

- Parametrised sequential shift-and-add multiplier. Next generation of the team's 4-bit sequential multiplier.
- Adds generic operand width, signed/unsigned mode selected per operation, a ready/valid input handshake and a one-cycle done pulse.
- Sits as an arithmetic unit behind a controller that issues one multiply at a time and waits for done.

---
 rtl/mult_seq_param.sv | 106 ++++++++++
 tb/tb_mult_seq_param.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
// Sequential shift-and-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Per-op signed/unsigned mode, ready/valid request, one-cycle done pulse.
module mult_seq_param #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic               accept;
  logic               last;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Magnitude as an unsigned WIDTH-bit value; most negative maps to 2^(W-1).
  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] v,
    input logic             sm
  );
    if (sm && v[WIDTH-1]) return ~v + WIDTH'(1);
    return v;
  endfunction

  assign mag_a  = mag(A, signed_mode);
  assign mag_b  = mag(B, signed_mode);
  assign accept = (state_q == IDLE) && valid;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  // One iteration of add-if-LSB and final sign fix-up of the product.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc + mcand;
    result = neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;
  end

  // Next-state logic: leave IDLE on accept, leave CALC on WIDTH-th edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (valid) state_d = CALC;
      CALC: if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == IDLE);
      done    <= (state_q == CALC) && last;
    end
  end

  // Datapath: latch magnitudes on accept, iterate in CALC, publish on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      prod   <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= '0;
      neg    <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    end else if (state_q == CALC) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last) prod <= result;
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param at WIDTH=4 and WIDTH=8.
// Hand-computed products, latency and handshake checked with assertions.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid4, sm4, ready4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;
  logic        valid8, sm8, ready8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .valid(valid4), .signed_mode(sm4),
    .A(a4), .B(b4), .ready(ready4), .prod(prod4), .done(done4)
  );

  mult_seq_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .valid(valid8), .signed_mode(sm8),
    .A(a8), .B(b8), .ready(ready8), .prod(prod8), .done(done8)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge; issues one op and follows it to done.
  task automatic op4(input string tag, input logic sm, input logic [3:0] a,
                     input logic [3:0] b, input logic [7:0] exp);
    logic [7:0] prev;
    prev = prod4;
    valid4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
    @(negedge clk);
    valid4 = 1'b0;
    chk({tag, "_busy"}, 16'(ready4), 16'd0);
    repeat (3) begin
      @(negedge clk);
      chk({tag, "_nodone"}, 16'(done4), 16'd0);
      chk({tag, "_hold"}, 16'(prod4), 16'(prev));
    end
    @(negedge clk);
    chk({tag, "_done"}, 16'(done4), 16'd1);
    chk({tag, "_rdy"}, 16'(ready4), 16'd1);
    chk({tag, "_prod"}, 16'(prod4), 16'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 16'(done4), 16'd0);
  endtask

  task automatic op8(input string tag, input logic sm, input logic [7:0] a,
                     input logic [7:0] b, input logic [15:0] exp);
    valid8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(negedge clk);
    valid8 = 1'b0;
    chk({tag, "_busy"}, 16'(ready8), 16'd0);
    repeat (7) begin
      @(negedge clk);
      chk({tag, "_nodone"}, 16'(done8), 16'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 16'(done8), 16'd1);
    chk({tag, "_prod"}, prod8, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 16'(done8), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    valid4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    valid8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready4", 16'(ready4), 16'd1);
    chk("rst_done4", 16'(done4), 16'd0);
    chk("rst_prod4", 16'(prod4), 16'd0);
    chk("rst_ready8", 16'(ready8), 16'd1);
    chk("rst_prod8", prod8, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    op4("u7x7", 1'b0, 4'd7, 4'd7, 8'h31);
    op4("s_m3x5", 1'b1, 4'b1101, 4'b0101, 8'hF1);
    op4("s_m8xm8", 1'b1, 4'b1000, 4'b1000, 8'h40);
    op4("u15x15", 1'b0, 4'hF, 4'hF, 8'hE1);
    op4("s_m1xm1", 1'b1, 4'hF, 4'hF, 8'h01);
    op4("s_0xm5", 1'b1, 4'd0, 4'b1011, 8'h00);
    op4("s_7xm8", 1'b1, 4'd7, 4'b1000, 8'hC8);

    // Busy request ignored, then back-to-back accept on the done cycle.
    valid4 = 1'b1; sm4 = 1'b0; a4 = 4'd3; b4 = 4'd4;
    @(negedge clk);
    valid4 = 1'b0;
    @(negedge clk);
    valid4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    @(negedge clk);
    valid4 = 1'b0;
    chk("busy_hold", 16'(prod4), 16'h00C8);
    @(negedge clk);
    chk("busy_nodone", 16'(done4), 16'd0);
    @(negedge clk);
    chk("b2b_done1", 16'(done4), 16'd1);
    chk("b2b_rdy1", 16'(ready4), 16'd1);
    chk("b2b_prod1", 16'(prod4), 16'h000C);
    valid4 = 1'b1; a4 = 4'd2; b4 = 4'd5;
    @(negedge clk);
    valid4 = 1'b0; a4 = 4'd9; b4 = 4'd9;
    chk("b2b_busy", 16'(ready4), 16'd0);
    chk("b2b_pulse", 16'(done4), 16'd0);
    repeat (3) begin
      chk("b2b_hold", 16'(prod4), 16'h000C);
      @(negedge clk);
      chk("b2b_nodone", 16'(done4), 16'(0));
    end
    @(negedge clk);
    chk("b2b_done2", 16'(done4), 16'd1);
    chk("b2b_prod2", 16'(prod4), 16'h000A);
    @(negedge clk);

    // Reset during the second CALC cycle aborts the operation.
    valid4 = 1'b1; a4 = 4'd6; b4 = 4'd6;
    @(negedge clk);
    valid4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 16'(ready4), 16'd1);
    chk("abort_done", 16'(done4), 16'd0);
    chk("abort_prod", 16'(prod4), 16'd0);
    repeat (10) begin
      @(negedge clk);
      chk("abort_nodone", 16'(done4), 16'd0);
    end

    op8("u255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8("s_m128x127", 1'b1, 8'h80, 8'h7F, 16'hC080);
    op8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
